conv_frame_ctrl: RTL
====================

Name: conv_frame_ctrl

Overview:
Sequencer in front of conv_top. It holds nine shadow kernel coefficients written from the CSR side. On start it loads them into conv_top's kernel port, then streams exactly IMG_W*IMG_H pixels from a ready/valid source into conv_top's valid_in/px_in. It counts conv_top output pixels and reports done, timeout and a one-cycle irq, giving the LiteX SoC a single start/done interface to the convolution datapath.

Parameters:
PIX_W, 8, pixel width
COEF_W, 16, signed coefficient width
IMG_W, 64, frame width in pixels
IMG_H, 64, frame height in pixels
EXP_OUT, 3844, expected conv_top outputs per frame ((IMG_W-2)*(IMG_H-2))
DRAIN_TO, 256, idle cycles allowed in DRAIN without a conv output before timeout

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-high
start  in  1  one-cycle frame start request
abort  in  1  one-cycle abort request
coef_we  in  1  shadow coefficient write strobe
coef_waddr  in  4  shadow index 0..8
coef_wdata  in  COEF_W  signed coefficient
src_valid  in  1  source pixel valid
src_data  in  PIX_W  source pixel
src_ready  out  1  controller accepts pixel
kernel_wr  out  1  to conv_top kernel_wr
kernel_addr  out  4  to conv_top kernel_addr
kernel_data  out  COEF_W  to conv_top kernel_data
valid_in  out  1  to conv_top valid_in
px_in  out  PIX_W  to conv_top px_in
conv_valid_out  in  1  from conv_top valid_out
busy  out  1  FSM not IDLE
done  out  1  sticky frame complete
err_timeout  out  1  sticky drain timeout
irq  out  1  one-cycle completion pulse
out_count  out  32  conv outputs counted this frame

Behaviour:
- Reset (rstn=1, async) drives every output to 0, clears all shadow coefficients to 0, clears all counters and sets the FSM to IDLE. All outputs are registered.
- Shadow writes: coef_we with coef_waddr<=8 writes the shadow register when busy=0. Writes while busy=1 or with addr>8 are ignored.
- FSM states: IDLE, LOAD_K, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 → LOAD_K.
  - On entry to LOAD_K, done, err_timeout, out_count and the pixel counter clear.
  - start while busy is ignored.
- LOAD_K:
  - kernel_wr=1 for exactly 9 consecutive cycles, beginning the cycle after start is sampled.
  - kernel_addr steps 0..8; kernel_data = shadow[kernel_addr].
  - Then → STREAM with kernel_wr=0.
- STREAM:
  - src_ready=1.
  - Each handshake (src_valid & src_ready) produces valid_in=1 and px_in=src_data on the next cycle (latency 1). Otherwise valid_in=0 (bubbles pass through) and px_in holds its last value.
  - Pixel counter increments per handshake.
  - On the handshake that makes the count IMG_W*IMG_H: src_ready drops the next cycle and the FSM → DRAIN. No further pixels are accepted.
- out_count:
  - Increments on conv_valid_out=1 in STREAM and DRAIN; ignored in IDLE, LOAD_K and DONE.
  - Saturates at 2^32-1.
- DRAIN:
  - Drain counter clears on every conv_valid_out.
  - out_count == EXP_OUT → DONE.
  - Drain counter reaching DRAIN_TO → err_timeout=1, then DONE.
  - If both occur in the same cycle, success wins and err_timeout stays 0.
- DONE: one cycle; irq=1, done=1 (sticky until the next start), → IDLE.
- abort:
  - Any non-IDLE state → IDLE next cycle.
  - kernel_wr, valid_in and src_ready go 0; no irq; done stays 0; counters are held for readback.
  - abort in IDLE has no effect. abort has priority over start and over all state transitions.
- Reset asserted mid-frame: immediate return to the reset values above; conv_top must be re-loaded by a new start.

Test Plan:
- Write shadow 0..8 = 1..9, start → kernel_wr high for exactly 9 cycles, addr 0..8, data 1..9, then src_ready=1 the following cycle.
- IMG_W=4, IMG_H=4, EXP_OUT=4, src_valid held 1, conv model emitting 4 outputs → 16 valid_in pulses, each one cycle after its handshake; done=1, irq single pulse, out_count=4, err_timeout=0.
- Same frame with src_valid toggling every other cycle → exactly 16 valid_in pulses with gaps; px_in sequence matches the source order.
- Conv model emits only 3 outputs, DRAIN_TO=8 → err_timeout=1 eight cycles after the last output, done=1, irq pulse, out_count=3.
- abort during STREAM after 5 pixels → busy=0 next cycle, src_ready=0, no irq, done=0. A coef write during LOAD_K is ignored; a subsequent start reloads the original values.
- Assert rstn mid-DRAIN → all outputs 0 immediately, shadow registers read back 0 on the next load (kernel_data=0 for addr 0..8).

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for conv_top: loads nine shadow coefficients, streams one
// frame of pixels, then counts convolution outputs until done or drain timeout.
module conv_frame_ctrl #(
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 16,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int EXP_OUT  = 3844,
  parameter int DRAIN_TO = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              coef_we,
  input  logic [3:0]        coef_waddr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              src_valid,
  input  logic [PIX_W-1:0]  src_data,
  output logic              src_ready,
  output logic              kernel_wr,
  output logic [3:0]        kernel_addr,
  output logic [COEF_W-1:0] kernel_data,
  output logic              valid_in,
  output logic [PIX_W-1:0]  px_in,
  input  logic              conv_valid_out,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              irq,
  output logic [31:0]       out_count
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int PCW   = $clog2(TOTAL + 1);
  localparam int DCW   = $clog2(DRAIN_TO + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [COEF_W-1:0]   shadow [9];
  logic [PCW-1:0]      pix_cnt_reg;
  logic [DCW-1:0]      drain_cnt_reg;
  logic                src_ready_reg, kernel_wr_reg, valid_in_reg;
  logic                busy_reg, done_reg, err_timeout_reg, irq_reg;
  logic [3:0]          kernel_addr_reg, kaddr_next;
  logic [COEF_W-1:0]   kernel_data_reg;
  logic [PIX_W-1:0]    px_in_reg;
  logic [31:0]         out_count_reg;
  logic                accept, last_px, success, timeout, start_take, counting;

  // Each shadow coefficient is only writable while the sequencer is idle.
  for (genvar gi = 0; gi < 9; gi++) begin : g_shadow
    logic [COEF_W-1:0] coef_q;
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn)
        coef_q <= '0;
      else if (coef_we && !busy_reg && coef_waddr == 4'(gi))
        coef_q <= coef_wdata;
    end
    assign shadow[gi] = coef_q;
  end

  assign accept     = (state_reg == S_STREAM) && src_ready_reg && src_valid && !abort;
  assign last_px    = accept && (pix_cnt_reg == PCW'(TOTAL - 1));
  assign success    = (out_count_reg == 32'(EXP_OUT));
  assign timeout    = !conv_valid_out && (drain_cnt_reg == DCW'(DRAIN_TO - 1));
  assign start_take = (state_reg == S_IDLE) && (state_next == S_LOAD_K);
  assign counting   = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
  assign kaddr_next = (state_reg == S_IDLE) ? 4'd0 : kernel_addr_reg + 4'd1;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_LOAD_K;
      S_LOAD_K: if (kernel_addr_reg == 4'd8) state_next = S_STREAM;
      S_STREAM: if (last_px) state_next = S_DRAIN;
      S_DRAIN:  if (success || timeout) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    // Abort overrides every transition but is meaningless when already idle.
    if (abort && state_reg != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      src_ready_reg   <= 1'b0;
      kernel_wr_reg   <= 1'b0;
      kernel_addr_reg <= '0;
      kernel_data_reg <= '0;
      valid_in_reg    <= 1'b0;
      px_in_reg       <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_timeout_reg <= 1'b0;
      irq_reg         <= 1'b0;
      out_count_reg   <= '0;
      pix_cnt_reg     <= '0;
      drain_cnt_reg   <= '0;
    end else begin
      kernel_wr_reg <= (state_next == S_LOAD_K);
      src_ready_reg <= (state_next == S_STREAM);
      busy_reg      <= (state_next != S_IDLE);
      irq_reg       <= (state_next == S_DONE);
      valid_in_reg  <= accept;

      if (state_next == S_LOAD_K) begin
        kernel_addr_reg <= kaddr_next;
        kernel_data_reg <= shadow[kaddr_next];
      end

      if (accept) px_in_reg <= src_data;

      if (start_take) begin
        done_reg        <= 1'b0;
        err_timeout_reg <= 1'b0;
        out_count_reg   <= '0;
        pix_cnt_reg     <= '0;
      end else begin
        if (accept) pix_cnt_reg <= pix_cnt_reg + PCW'(1);
        if (counting && conv_valid_out && out_count_reg != '1)
          out_count_reg <= out_count_reg + 32'd1;
        if (state_next == S_DONE) done_reg <= 1'b1;
        // A simultaneous success suppresses the timeout flag.
        if (state_reg == S_DRAIN && state_next == S_DONE && !success)
          err_timeout_reg <= 1'b1;
      end

      if (state_reg != S_DRAIN || conv_valid_out) drain_cnt_reg <= '0;
      else                                        drain_cnt_reg <= drain_cnt_reg + DCW'(1);
    end
  end

  assign src_ready   = src_ready_reg;
  assign kernel_wr   = kernel_wr_reg;
  assign kernel_addr = kernel_addr_reg;
  assign kernel_data = kernel_data_reg;
  assign valid_in    = valid_in_reg;
  assign px_in       = px_in_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err_timeout = err_timeout_reg;
  assign irq         = irq_reg;
  assign out_count   = out_count_reg;

endmodule
